// File: rtl/bram_transpose_ctrl.sv
// N x N transpose controller: fills one BRAM row-major, drains it column-major through a 4-deep credit FIFO.
// Optional performance counters are enabled with `define TRANSPOSE_CTRL_PERF_EN.
module bram_transpose_ctrl #(
    parameter int unsigned DATAW = 8,
    parameter int unsigned MAT_N = 8,
    parameter int unsigned IDXW  = $clog2(MAT_N),
    parameter int unsigned ADDRW = 2 * IDXW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DATAW-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DATAW-1:0] m_data,
    output logic             m_last,
`ifdef TRANSPOSE_CTRL_PERF_EN
    output logic [31:0]      perf_mats,
    output logic [31:0]      perf_stall,
`endif
    output logic [DATAW-1:0] bram_wdata,
    output logic [ADDRW-1:0] bram_waddr,
    output logic             bram_wen,
    output logic [ADDRW-1:0] bram_raddr,
    input  logic [DATAW-1:0] bram_rdata
);

    localparam int unsigned FIFO_D = 4;
    localparam int unsigned PTRW   = 2;
    localparam int unsigned CNTW   = 3;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(MAT_N - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   wr_row_q, wr_col_q;
    logic [IDXW-1:0]   rd_row_q, rd_col_q;
    logic              rd_done_q;
    logic [1:0]        vld_q;
    logic [DATAW-1:0]  fifo_mem_q [FIFO_D];
    logic [PTRW-1:0]   wptr_q, rptr_q;
    logic [CNTW-1:0]   fifo_cnt_q;
    logic [ADDRW-1:0]  out_cnt_q;

    logic              accept;
    logic              wr_last;
    logic              rd_issue;
    logic              push;
    logic              pop;
    logic              last_hs;
    logic [CNTW-1:0]   inflight;
    logic [CNTW:0]     credit_used;

    // Next state and combinational port drive
    always_comb begin
        state_d     = state_q;
        s_ready     = 1'b0;
        accept      = 1'b0;
        rd_issue    = 1'b0;
        inflight    = CNTW'(vld_q[0]) + CNTW'(vld_q[1]);
        credit_used = {1'b0, fifo_cnt_q} + {1'b0, inflight};
        wr_last     = (wr_row_q == LAST_IDX) && (wr_col_q == LAST_IDX);
        push        = vld_q[1];
        m_valid     = (fifo_cnt_q != '0);
        m_data      = fifo_mem_q[rptr_q];
        m_last      = m_valid && (out_cnt_q == '1);
        pop         = m_valid && m_ready;
        last_hs     = pop && m_last;

        unique case (state_q)
            FILL: begin
                s_ready = 1'b1;
                accept  = s_valid;
                if (accept && wr_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                rd_issue = !rd_done_q && (credit_used < (CNTW + 1)'(FIFO_D));
                if (last_hs) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        bram_wen   = accept;
        bram_wdata = s_data;
        bram_waddr = {wr_row_q, wr_col_q};
        bram_raddr = {rd_row_q, rd_col_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Row-major write counters; natural wrap returns them to 0 after the last element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_row_q <= '0;
            wr_col_q <= '0;
        end else if (accept) begin
            wr_col_q <= wr_col_q + IDXW'(1);
            if (wr_col_q == LAST_IDX) begin
                wr_row_q <= wr_row_q + IDXW'(1);
            end
        end
    end

    // Column-major read counters and read-latency tracker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_row_q  <= '0;
            rd_col_q  <= '0;
            rd_done_q <= 1'b0;
            vld_q     <= '0;
        end else begin
            vld_q <= {vld_q[0], rd_issue};
            if (rd_issue) begin
                rd_row_q <= rd_row_q + IDXW'(1);
                if (rd_row_q == LAST_IDX) begin
                    rd_col_q <= rd_col_q + IDXW'(1);
                    if (rd_col_q == LAST_IDX) begin
                        rd_done_q <= 1'b1;
                    end
                end
            end
            if (last_hs) begin
                rd_done_q <= 1'b0;
            end
        end
    end

    // Output FIFO; credits guarantee a push never meets a full FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_D; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wptr_q] <= bram_rdata;
                wptr_q             <= wptr_q + PTRW'(1);
            end
            if (pop) begin
                rptr_q    <= rptr_q + PTRW'(1);
                out_cnt_q <= out_cnt_q + ADDRW'(1);
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + CNTW'(1);
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - CNTW'(1);
            end
        end
    end

`ifdef TRANSPOSE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_mats  <= '0;
            perf_stall <= '0;
        end else begin
            if (last_hs) begin
                perf_mats <= perf_mats + 32'd1;
            end
            if (m_valid && !m_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bram_transpose_ctrl.sv
// Scoreboard bench for bram_transpose_ctrl with a behavioural BRAM (registered inputs, one-cycle read).
module tb_bram_transpose_ctrl;

    localparam int unsigned DATAW = 8;
    localparam int unsigned MAT_N = 4;
    localparam int unsigned IDXW  = 2;
    localparam int unsigned ADDRW = 4;
    localparam int unsigned NN    = MAT_N * MAT_N;

    typedef struct packed {
        logic             last;
        logic [DATAW-1:0] data;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [DATAW-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [DATAW-1:0] m_data;
    logic             m_last;
    logic [DATAW-1:0] bram_wdata;
    logic [ADDRW-1:0] bram_waddr;
    logic             bram_wen;
    logic [ADDRW-1:0] bram_raddr;
    logic [DATAW-1:0] bram_rdata;
`ifdef TRANSPOSE_CTRL_PERF_EN
    logic [31:0]      perf_mats;
    logic [31:0]      perf_stall;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   mon_outs = 0;
    int   mode     = 0;
    exp_t exp_q[$];

    bram_transpose_ctrl #(
        .DATAW(DATAW), .MAT_N(MAT_N), .IDXW(IDXW), .ADDRW(ADDRW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
`ifdef TRANSPOSE_CTRL_PERF_EN
        .perf_mats(perf_mats), .perf_stall(perf_stall),
`endif
        .bram_wdata(bram_wdata), .bram_waddr(bram_waddr), .bram_wen(bram_wen),
        .bram_raddr(bram_raddr), .bram_rdata(bram_rdata)
    );

    // Behavioural BRAM: input register stage, then memory write / synchronous read
    logic [DATAW-1:0] mem [NN];
    logic             wen_r;
    logic [ADDRW-1:0] waddr_r, raddr_r;
    logic [DATAW-1:0] wdata_r;
    always @(posedge clk) begin
        wen_r   <= bram_wen;
        waddr_r <= bram_waddr;
        wdata_r <= bram_wdata;
        raddr_r <= bram_raddr;
        if (wen_r) mem[waddr_r] <= wdata_r;
        bram_rdata <= mem[raddr_r];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s bound expired at %0t", name, $time);
    endtask

    // Consumer-side ready generator
    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph  = 0;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0: m_ready = 1'b1;
                1: begin m_ready = pat[ph]; ph = (ph + 1) % 4; end
                2: m_ready = 1'($urandom_range(1));
                default: ;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake
    always @(negedge clk) begin
        static logic             hold_chk  = 1'b0;
        static logic [DATAW-1:0] hold_data = '0;
        static logic             last_seen = 1'b0;
        exp_t e;
        if (!rst_n) begin
            hold_chk  = 1'b0;
            last_seen = 1'b0;
        end else begin
            chk("wen_only_on_accept", 32'(bram_wen), 32'(s_valid && s_ready));
            if (hold_chk) begin
                chk("stall_valid_stable", 32'(m_valid), 32'd1);
                chk("stall_data_stable", 32'(m_data), 32'(hold_data));
            end
            if (last_seen) chk("s_ready_after_last", 32'(s_ready), 32'd1);
            if (m_valid && m_ready) begin
                mon_outs++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", 32'(m_data), 32'(e.data));
                    chk("m_last", 32'(m_last), 32'(e.last));
                end
            end
            hold_chk  = m_valid && !m_ready;
            hold_data = m_data;
            last_seen = m_valid && m_ready && m_last;
        end
    end

    // Send one matrix row-major; on completion queue its transpose
    task automatic send_matrix(input logic [DATAW-1:0] vals [NN], input int pct);
        int i = 0;
        int guard = 0;
        bit acc;
        exp_t e;
        while (i < NN && guard < 2000) begin
            s_valid = ($urandom_range(99) < pct);
            s_data  = vals[i];
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            guard++;
        end
        s_valid = 1'b0;
        if (i < NN) begin
            fail_now("send_timeout");
        end else begin
            for (int c = 0; c < MAT_N; c++) begin
                for (int r = 0; r < MAT_N; r++) begin
                    e.data = vals[r * MAT_N + c];
                    e.last = (r == MAT_N - 1) && (c == MAT_N - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || m_valid) && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 1000) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic seq_vals(input int base, output logic [DATAW-1:0] v [NN]);
        for (int i = 0; i < NN; i++) v[i] = DATAW'(base + i);
    endtask

    task automatic rand_vals(output logic [DATAW-1:0] v [NN]);
        for (int i = 0; i < NN; i++) v[i] = DATAW'($urandom);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATAW-1:0] v [NN];
        int g;
        rst_n   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_bram_wen", 32'(bram_wen), 32'd0);
        chk("rst_waddr", 32'(bram_waddr), 32'd0);
        chk("rst_raddr", 32'(bram_raddr), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Continuous stream 0..15 plus drain startup latency
        mode = 0;
        seq_vals(0, v);
        send_matrix(v, 100);
        @(negedge clk);
        chk("drain_first_raddr", 32'(bram_raddr), 32'd0);
        chk("drain_s_ready", 32'(s_ready), 32'd0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            chk("startup_m_valid", 32'(m_valid), 32'(k == 4));
        end
        wait_drain();

        // Backpressure 1-0-0-1
        mode = 1;
        rand_vals(v);
        send_matrix(v, 100);
        wait_drain();

        // Input gaps with random backpressure
        mode = 2;
        rand_vals(v);
        send_matrix(v, 50);
        wait_drain();
        seq_vals(0, v);
        send_matrix(v, 50);
        wait_drain();

        // Reset in the middle of a drain, then a fresh matrix
        mode = 0;
        mon_outs = 0;
        seq_vals(0, v);
        send_matrix(v, 100);
        g = 0;
        while (mon_outs < 5 && g < 200) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (g >= 200) fail_now("mid_drain_wait");
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(m_valid), 32'd0);
        chk("midrst_s_ready", 32'(s_ready), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        seq_vals(100, v);
        send_matrix(v, 100);
        wait_drain();

        for (int m = 0; m < 3; m++) begin
            mode = m % 3;
            rand_vals(v);
            send_matrix(v, 70);
            wait_drain();
        end

`ifdef TRANSPOSE_CTRL_PERF_EN
        mode = 0;
        pulse_reset();
        mode = 3;
        m_ready = 1'b0;
        seq_vals(0, v);
        send_matrix(v, 100);
        g = 0;
        begin
            int stalls = 0;
            while (stalls < 7 && g < 200) begin
                @(negedge clk);
                if (m_valid) stalls++;
                g++;
            end
        end
        if (g >= 200) fail_now("perf_stall_wait");
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        mode = 0;
        wait_drain();
        rand_vals(v);
        send_matrix(v, 100);
        wait_drain();
        chk("perf_mats", perf_mats, 32'd2);
        chk("perf_stall", perf_stall, 32'd7);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
